// File: rtl/raster_cmd_decoder_p.sv
// Assembles header+parameter bytes into raster commands; last byte accepted in N -> cmd_valid in N+1.
// in_ready is a register, low only while a command waits for cmd_ready; mid-command stalls time out.
module raster_cmd_decoder_p #(
    parameter int COORD_W = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2:0]         cmd,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] x2,
    output logic [COORD_W-1:0] y2,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               err_valid,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PARAM = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Timer holds the number of idle cycles already seen; fire on the TIMEOUT-th one.
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [6:0]    P_MASK = ~7'((1 << COORD_W) - 1);

    localparam logic [2:0] OP_NOOP  = 3'd0;
    localparam logic [2:0] OP_PIXEL = 3'd1;
    localparam logic [2:0] OP_LINE  = 3'd2;
    localparam logic [2:0] OP_RECT  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    localparam logic [1:0] E_RSVD    = 2'b01;
    localparam logic [1:0] E_TIMEOUT = 2'b10;
    localparam logic [1:0] E_PARAM   = 2'b11;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         op_q, op_d;
    logic [COORD_W-1:0] slot_q [4];
    logic [COORD_W-1:0] slot_d [4];
    logic               in_ready_q;
    logic               cmd_valid_q;
    logic               err_valid_q, err_d;
    logic [1:0]         err_code_q, code_d;
    logic               accept;
    logic               decode_hdr;
    logic [1:0]         last_idx;

    assign accept    = in_valid & in_ready_q;
    assign in_ready  = in_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign cmd       = op_q;
    assign x1        = slot_q[0];
    assign y1        = slot_q[1];
    assign x2        = slot_q[2];
    assign y2        = slot_q[3];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        op_d       = op_q;
        slot_d     = slot_q;
        err_d      = 1'b0;
        code_d     = err_code_q;
        decode_hdr = 1'b0;
        last_idx   = (op_q == OP_PIXEL) ? 2'd1 : 2'd3;

        case (state_q)
            ST_IDLE: begin
                decode_hdr = accept & in_data[7];
            end
            ST_PARAM: begin
                if (accept) begin
                    timer_d = '0;
                    if (in_data[7]) begin
                        // Header mid-command: drop the partial command, then treat the byte as a fresh header.
                        err_d      = 1'b1;
                        code_d     = E_PARAM;
                        state_d    = ST_IDLE;
                        decode_hdr = 1'b1;
                    end else if ((in_data[6:0] & P_MASK) != 7'd0) begin
                        err_d   = 1'b1;
                        code_d  = E_PARAM;
                        state_d = ST_IDLE;
                    end else begin
                        slot_d[idx_q] = in_data[COORD_W-1:0];
                        idx_d         = idx_q + 2'd1;
                        if (idx_q == last_idx) begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else if ((TIMEOUT > 0) && (timer_q == T_LAST)) begin
                    err_d   = 1'b1;
                    code_d  = E_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (decode_hdr) begin
            case (in_data[6:4])
                OP_NOOP: begin
                    state_d = ST_IDLE;
                end
                OP_PIXEL, OP_LINE, OP_RECT: begin
                    op_d = in_data[6:4];
                    for (int i = 0; i < 4; i++) begin
                        slot_d[i] = '0;
                    end
                    idx_d   = 2'd0;
                    timer_d = '0;
                    state_d = ST_PARAM;
                end
                OP_CLEAR: begin
                    op_d = OP_CLEAR;
                    for (int i = 0; i < 4; i++) begin
                        slot_d[i] = '0;
                    end
                    state_d = ST_ISSUE;
                end
                default: begin
                    // A dropped command already reports bad-parameter this cycle; keep that code.
                    if (!err_d) begin
                        err_d  = 1'b1;
                        code_d = E_RSVD;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            timer_q     <= '0;
            op_q        <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            in_ready_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            op_q        <= op_d;
            slot_q      <= slot_d;
            in_ready_q  <= (state_d != ST_ISSUE);
            cmd_valid_q <= (state_d == ST_ISSUE);
            err_valid_q <= err_d;
            err_code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_raster_cmd_decoder_p.sv
// Bench for raster_cmd_decoder_p: directed cases plus randomized byte streams against a rule-level model.
module tb_raster_cmd_decoder_p;

    localparam int CW  = 3;
    localparam int CW6 = 6;
    localparam int TO  = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     in_data = 8'h00;
    logic           in_valid = 1'b0;
    logic           cmd_ready = 1'b1;

    logic           in_ready, cmd_valid, err_valid;
    logic [2:0]     cmd;
    logic [1:0]     err_code;
    logic [CW-1:0]  x1, y1, x2, y2;

    logic           b_in_ready, b_cmd_valid, b_err_valid;
    logic [2:0]     b_cmd;
    logic [1:0]     b_err_code;
    logic [CW6-1:0] b_x1, b_y1, b_x2, b_y2;

    raster_cmd_decoder_p #(.COORD_W(CW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .err_valid(err_valid), .err_code(err_code)
    );

    raster_cmd_decoder_p #(.COORD_W(CW6), .TIMEOUT(TO)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .cmd(b_cmd), .x1(b_x1), .y1(b_y1), .x2(b_x2), .y2(b_y2), .cmd_valid(b_cmd_valid),
        .cmd_ready(cmd_ready), .err_valid(b_err_valid), .err_code(b_err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Rule-level model: a pending command, a partially assembled one, and an idle count.
    bit         mon_on = 1'b0;
    bit         m_pend, m_asm, m_errv;
    logic [1:0] m_code;
    int         m_op, m_cmd, m_idle;
    int         m_par[$];
    int         m_out[4];

    function automatic int need(input int op);
        return (op == 1) ? 2 : 4;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_asm = 0; m_errv = 0; m_code = 2'b00;
        m_op = 0; m_cmd = 0; m_idle = 0;
        m_par.delete();
        m_out = '{0, 0, 0, 0};
    endtask

    task automatic model_step(input bit vld, input logic [7:0] d, input bit rdy);
        bit         acc, err;
        logic [1:0] code;
        int         op;
        acc  = vld && !m_pend;
        err  = 0;
        code = m_code;
        if (m_pend && rdy) m_pend = 0;
        if (acc && d[7]) begin
            if (m_asm) begin
                err = 1; code = 2'b11; m_asm = 0;
            end
            op = int'(d[6:4]);
            if (op == 4) begin
                m_pend = 1; m_cmd = 4; m_out = '{0, 0, 0, 0};
            end else if (op >= 1 && op <= 3) begin
                m_asm = 1; m_op = op; m_par.delete(); m_idle = 0;
            end else if (op >= 5 && !err) begin
                err = 1; code = 2'b01;
            end
        end else if (acc && m_asm) begin
            m_idle = 0;
            if ((int'(d[6:0]) >> CW) != 0) begin
                err = 1; code = 2'b11; m_asm = 0;
            end else begin
                m_par.push_back(int'(d[6:0]));
                if (m_par.size() == need(m_op)) begin
                    m_asm = 0; m_pend = 1; m_cmd = m_op;
                    for (int i = 0; i < 4; i++) m_out[i] = (i < m_par.size()) ? m_par[i] : 0;
                end
            end
        end else if (!acc && m_asm) begin
            m_idle++;
            if (m_idle == TO) begin
                err = 1; code = 2'b10; m_asm = 0;
            end
        end
        m_errv = err;
        m_code = code;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("m_in_ready", in_ready, !m_pend);
            check("m_cmd_valid", cmd_valid, m_pend);
            if (m_pend) begin
                check("m_cmd", cmd, m_cmd);
                check("m_x1", x1, m_out[0]);
                check("m_y1", y1, m_out[1]);
                check("m_x2", x2, m_out[2]);
                check("m_y2", y2, m_out[3]);
            end
            check("m_err_valid", err_valid, m_errv);
            check("m_err_code", err_code, m_code);
            model_step(in_valid, in_data, cmd_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_on   = 0;
        in_valid = 0;
        rst_n    = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick();
        model_reset();
        mon_on = 1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int w;
        bit acc;
        in_valid = 1; in_data = d; w = 0; acc = 0;
        while (!acc && w < 50) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            w++;
        end
        in_valid = 0;
        check("accept_wait", acc, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, gap, r;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cmd_xy", {cmd, x1, y1, x2, y2}, 0);
        do_reset();
        check("ready_after_rst", in_ready, 1);

        // PIXEL with the rasterizer ready
        cmd_ready = 1;
        send_byte(8'h90); send_byte(8'h03); send_byte(8'h05);
        check("pix_valid", cmd_valid, 1);
        check("pix_cmd", cmd, 1);
        check("pix_x1", x1, 3);
        check("pix_y1", y1, 5);
        check("pix_unused", {x2, y2}, 0);
        tick();
        check("pix_ready_back", in_ready, 1);
        check("pix_valid_drop", cmd_valid, 0);

        // LINE held under back-pressure
        cmd_ready = 0;
        send_byte(8'hA0); send_byte(8'h01); send_byte(8'h02); send_byte(8'h06); send_byte(8'h07);
        for (int k = 0; k < 5; k++) begin
            check("line_hold", cmd_valid, 1);
            check("line_in_ready", in_ready, 0);
            check("line_xy", {cmd, x1, y1, x2, y2}, {3'd2, 3'd1, 3'd2, 3'd6, 3'd7});
            tick();
        end
        cmd_ready = 1;
        tick();
        check("line_taken", cmd_valid, 0);
        check("line_ready_back", in_ready, 1);

        // RECT stalled mid-command
        send_byte(8'hB0); send_byte(8'h01);
        w = 0;
        while (!err_valid && w < 40) begin
            tick();
            w++;
        end
        check("to_wait", w, 15);
        check("to_code", err_code, 2'b10);
        tick();
        check("to_pulse", err_valid, 0);
        check("to_code_held", err_code, 2'b10);

        send_byte(8'hE0);
        check("rsv_err", err_valid, 1);
        check("rsv_code", err_code, 2'b01);

        send_byte(8'h90); send_byte(8'hC0);
        check("bh_err", err_valid, 1);
        check("bh_code", err_code, 2'b11);
        check("bh_clear", {cmd_valid, cmd, x1, y1, x2, y2}, {1'b1, 3'd4, 12'd0});
        tick();

        send_byte(8'h90); send_byte(8'h09);
        check("bp_err", err_valid, 1);
        check("bp_code", err_code, 2'b11);
        check("bp_no_cmd", cmd_valid, 0);
        repeat (20) tick();

        // Wide coordinates on the COORD_W=6 instance
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h3F); send_byte(8'h3F); send_byte(8'h00);
        check("w6_valid", b_cmd_valid, 1);
        check("w6_cmd", b_cmd, 2);
        check("w6_x1", b_x1, 0);
        check("w6_y1", b_y1, 63);
        check("w6_x2", b_x2, 63);
        check("w6_y2", b_y2, 0);
        tick();

        // Asynchronous reset while collecting parameters
        send_byte(8'hA0); send_byte(8'h01);
        #2 mon_on = 0; rst_n = 0;
        #1;
        check("rstp_a", {in_ready, cmd_valid, err_valid, err_code, cmd, x1, y1, x2, y2}, 0);
        check("rstp_b", {b_in_ready, b_cmd_valid, b_err_valid, b_err_code, b_cmd, b_x1, b_y1, b_x2, b_y2}, 0);
        do_reset();

        // Asynchronous reset while a command is being offered
        cmd_ready = 0;
        send_byte(8'h90); send_byte(8'h01); send_byte(8'h02);
        check("rsti_valid", cmd_valid, 1);
        #2 mon_on = 0; rst_n = 0;
        #1;
        check("rsti_drop", {cmd_valid, err_valid, b_cmd_valid}, 0);
        cmd_ready = 1;
        do_reset();

        gap = 0;
        for (int c = 0; c < 4000; c++) begin
            if (gap > 0) begin
                in_valid = 0;
                gap--;
            end else if ($urandom_range(0, 99) < 2) begin
                in_valid = 0;
                gap = $urandom_range(13, 17);
            end else begin
                in_valid = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 99);
                if (r < 30)      in_data = {1'b1, 3'($urandom_range(0, 7)), 4'($urandom)};
                else if (r < 90) in_data = {1'b0, 7'($urandom_range(0, 7))};
                else             in_data = {1'b0, 7'($urandom)};
            end
            cmd_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid = 0;
        @(negedge clk);
        #1 mon_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
